// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  modport slave (
    input  req,
    output gnt,
    output sel,
    output busy
  );

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  busy
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter with bounded hold time for a shared 4:1 mux
module rr_arbiter4 #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter4_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [3:0]       gnt_q, gnt_n;
  logic [1:0]       sel_q, sel_n;
  logic [1:0]       last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [1:0]       pick_base;
  logic [3:0]       pick_req;
  logic [1:0]       win;
  logic [3:0]       others;
  logic             owner_req;

  // First requester strictly after base, wrapping; base itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign others    = bus.req & ~gnt_q;
  assign owner_req = bus.req[sel_q];
  assign pick_base = (state == IDLE) ? last_q : sel_q;
  assign pick_req  = (state == IDLE) ? bus.req : others;
  assign win       = rr_pick(pick_base, pick_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= 4'b0000;
      sel_q  <= 2'b00;
      last_q <= 2'd3;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      gnt_q  <= gnt_n;
      sel_q  <= sel_n;
      last_q <= last_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          sel_n   = win;
          last_n  = win;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (!owner_req && others != 4'b0000) begin
          gnt_n  = 4'b0001 << win;
          sel_n  = win;
          last_n = win;
          cnt_n  = '0;
        end else if (!owner_req) begin
          // sel is left alone so the mux keeps pointing at the last owner
          state_n = IDLE;
          gnt_n   = 4'b0000;
          cnt_n   = '0;
        end else if (others != 4'b0000 && cnt_q == HOLD_LAST) begin
          gnt_n  = 4'b0001 << win;
          sel_n  = win;
          last_n = win;
          cnt_n  = '0;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = (gnt_q != 4'b0000);

endmodule
